// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-vector encodings,
// multi-cycle FSM state type and the default exception fetch vector.
package pipe_ctrl_pkg;

  // stall bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [31:0] EXCP_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core.
//  - Freezes pipeline registers via stall[5:0], flushes them via flush.
//  - Sequences the multi-cycle EX unit (start/cancel handshake, timeout).
//  - Redirects fetch to EXCP_VECTOR on a MEM-stage exception.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  stallreq_id/ex    single-cycle stall requests from ID / EX
//  ex_mc_req         EX holds a multi-cycle op (level)
//  mc_done           multi-cycle result valid (pulse)
//  mem_excp          MEM-stage exception this cycle
//  stall, flush,     hold vector, flush strobe and redirect target
//  new_pc            (combinational, consumed at the same edge)
//  mc_start/cancel   launch/abort pulses to the multi-cycle unit
//  mc_timeout        sticky timeout error flag
//  stall_cycles      saturating count of cycles with any stall bit set
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned  MC_TIMEOUT  = 64,
  parameter logic [31:0]  EXCP_VECTOR = EXCP_VECTOR_DEF,
  parameter int unsigned  CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             ex_mc_req,
  input  logic             mc_done,
  input  logic             mem_excp,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mc_start,
  output logic             mc_cancel,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned     TMR_W    = $clog2(MC_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

  mc_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic             mc_hold;
  logic             start_c;
  logic             cancel_c;

  // Multi-cycle FSM next-state; an exception in MEM overrides done/timeout.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mc_timeout_d = mc_timeout_q;
    mc_hold      = 1'b0;
    start_c      = 1'b0;
    cancel_c     = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        if (ex_mc_req && !mem_excp) begin
          start_c = 1'b1;
          mc_hold = 1'b1;
          timer_d = '0;
          state_d = MC_RUN;
        end
      end
      MC_RUN: begin
        mc_hold = 1'b1;
        timer_d = timer_q + 1'b1;
        if (mem_excp) begin
          cancel_c = 1'b1;
          state_d  = MC_IDLE;
        end else if (mc_done) begin
          state_d = MC_DONE;
        end else if (timer_q == TMR_LAST) begin
          cancel_c     = 1'b1;
          mc_timeout_d = 1'b1;
          state_d      = MC_IDLE;
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  // Pipeline control outputs; all forced low while in reset.
  always_comb begin
    stall     = STALL_NONE;
    flush     = 1'b0;
    new_pc    = '0;
    mc_start  = 1'b0;
    mc_cancel = 1'b0;
    if (!rst) begin
      if (mem_excp) begin
        flush     = 1'b1;
        new_pc    = EXCP_VECTOR;
        mc_cancel = cancel_c;
      end else begin
        mc_start  = start_c;
        mc_cancel = cancel_c;
        if (mc_hold || stallreq_ex) stall = STALL_EX;
        else if (stallreq_id)       stall = STALL_ID;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall != STALL_NONE) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MC_IDLE;
      timer_q        <= '0;
      mc_timeout_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      mc_timeout_q   <= mc_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mc_timeout   = mc_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0;
  logic        ex_mc_req = 1'b0, mc_done = 1'b0, mem_excp = 1'b0;
  logic [5:0]  stall;
  logic        flush, mc_start, mc_cancel, mc_timeout;
  logic [31:0] new_pc;
  logic [3:0]  stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.MC_TIMEOUT(TO), .EXCP_VECTOR(32'h0000_0020), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_mc_req(ex_mc_req), .mc_done(mc_done), .mem_excp(mem_excp),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .mc_start(mc_start), .mc_cancel(mc_cancel), .mc_timeout(mc_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1; outputs are sampled at posedge+5.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id = 0; stallreq_ex = 0; ex_mc_req = 0; mc_done = 0; mem_excp = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    stallreq_id = 1; stallreq_ex = 1; ex_mc_req = 1; mem_excp = 1;
    #4;
    checks++;
    if ({stall, flush, new_pc, mc_start, mc_cancel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b flush=%b new_pc=%h start=%b cancel=%b want all 0",
               stall, flush, new_pc, mc_start, mc_cancel);
    end
    tick();
    clear_inputs();
    rst = 0;
    #4;
    checks++;
    if (mc_timeout !== 1'b0 || stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: timeout=%b cycles=%0d want 0/0", mc_timeout, stall_cycles);
    end
    tick();
  endtask

  task automatic test_stall_id();
    do_reset();
    stallreq_id = 1;
    #4;
    checks++;
    if (stall !== 6'b000111) begin
      errors++; $display("FAIL stall_id: got %b want 000111", stall);
    end
    tick();
    stallreq_id = 0;
    #4;
    checks++;
    if (stall !== 6'b000000 || stall_cycles !== 4'd1) begin
      errors++; $display("FAIL stall_id_count: stall=%b cycles=%0d want 000000/1", stall, stall_cycles);
    end
    tick();
  endtask

  task automatic test_stall_ex();
    do_reset();
    stallreq_id = 1; stallreq_ex = 1;
    #4;
    checks++;
    if (stall !== 6'b001111) begin
      errors++; $display("FAIL stall_ex_prio: got %b want 001111", stall);
    end
    tick();
    mem_excp = 1;
    #4;
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b1 || new_pc !== 32'h20) begin
      errors++; $display("FAIL excp_over_stall: stall=%b flush=%b pc=%h want 000000/1/20", stall, flush, new_pc);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mc_op();
    int starts = 0;
    int held = 0;
    do_reset();
    ex_mc_req = 1;
    for (int c = 0; c < 6; c++) begin
      mc_done = (c == 5);
      #4;
      if (mc_start) starts++;
      if (stall == 6'b001111) held++;
      tick();
    end
    mc_done = 0;
    #4;
    checks++;
    if (stall !== 6'b000000 || mc_start !== 1'b0) begin
      errors++; $display("FAIL mc_done_release: stall=%b start=%b want 000000/0", stall, mc_start);
    end
    checks++;
    if (starts != 1 || held != 6) begin
      errors++; $display("FAIL mc_op_shape: starts=%0d held=%0d want 1/6", starts, held);
    end
    tick();
    ex_mc_req = 0;
    #4;
    checks++;
    if (stall_cycles !== 4'd6) begin
      errors++; $display("FAIL mc_op_count: got %0d want 6", stall_cycles);
    end
    tick();
  endtask

  task automatic test_mc_excp();
    do_reset();
    ex_mc_req = 1;
    tick();
    mem_excp = 1; mc_done = 1;
    #4;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0 || mc_cancel !== 1'b1 || mc_start !== 1'b0) begin
      errors++;
      $display("FAIL mc_excp: flush=%b pc=%h stall=%b cancel=%b start=%b want 1/20/000000/1/0",
               flush, new_pc, stall, mc_cancel, mc_start);
    end
    tick();
    mem_excp = 0; mc_done = 0;
    #4;
    checks++;
    if (mc_start !== 1'b1 || flush !== 1'b0 || new_pc !== 32'h0) begin
      errors++; $display("FAIL mc_excp_idle: start=%b flush=%b pc=%h want 1/0/0", mc_start, flush, new_pc);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_mc_timeout();
    int cancel_at = -1;
    do_reset();
    ex_mc_req = 1;
    tick();
    for (int c = 1; c <= TO; c++) begin
      #4;
      if (mc_cancel && cancel_at < 0) cancel_at = c;
      tick();
    end
    ex_mc_req = 0;
    checks++;
    if (cancel_at != TO) begin
      errors++; $display("FAIL timeout_cancel: run_cycle=%0d want %0d", cancel_at, TO);
    end
    #4;
    checks++;
    if (mc_timeout !== 1'b1 || stall !== 6'b0) begin
      errors++; $display("FAIL timeout_flag: flag=%b stall=%b want 1/000000", mc_timeout, stall);
    end
    tick(); tick(); tick();
    #4;
    checks++;
    if (mc_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b want 1", mc_timeout);
    end
    tick();
  endtask

  task automatic test_rst_mid_run();
    do_reset();
    ex_mc_req = 1;
    tick(); tick();
    rst = 1;
    #4;
    checks++;
    if (mc_cancel !== 1'b0 || stall !== 6'b0) begin
      errors++; $display("FAIL rst_mid_run: cancel=%b stall=%b want 0/000000", mc_cancel, stall);
    end
    tick();
    rst = 0; ex_mc_req = 0;
    #4;
    checks++;
    if ({stall, flush, new_pc, mc_start, mc_cancel, mc_timeout, stall_cycles} !== '0) begin
      errors++;
      $display("FAIL rst_after: stall=%b flush=%b start=%b cancel=%b to=%b cycles=%0d want all 0",
               stall, flush, mc_start, mc_cancel, mc_timeout, stall_cycles);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    stallreq_id = 1;
    for (int c = 0; c < 20; c++) tick();
    stallreq_id = 0;
    #4;
    checks++;
    if (stall_cycles !== 4'hF) begin
      errors++; $display("FAIL counter_saturate: got %0d want 15", stall_cycles);
    end
    tick();
  endtask

  // Reference: an op is "in flight" from the start cycle until done/abort;
  // the cycle after done is the finishing cycle in which no new op launches.
  task automatic test_random();
    bit busy = 0, fin = 0, to = 0;
    int el = 0, cnt = 0;
    bit launch, cancel;
    logic [5:0] es;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom % 60 == 0);
      stallreq_id = ($urandom % 4 == 0);
      stallreq_ex = ($urandom % 7 == 0);
      ex_mc_req   = ($urandom % 3 != 0);
      mc_done     = ($urandom % 9 == 0);
      mem_excp    = ($urandom % 14 == 0);
      launch = !rst && !busy && !fin && ex_mc_req && !mem_excp;
      cancel = !rst && busy && (mem_excp || (!mc_done && el == TO - 1));
      if (rst || mem_excp) es = 6'b000000;
      else if (launch || busy || stallreq_ex) es = 6'b001111;
      else if (stallreq_id) es = 6'b000111;
      else es = 6'b000000;
      #4;
      checks++;
      if (stall !== es || flush !== (!rst && mem_excp) ||
          new_pc !== ((!rst && mem_excp) ? 32'h20 : 32'h0)) begin
        errors++;
        $display("FAIL rnd_pipe[%0d]: stall=%b flush=%b pc=%h want stall=%b excp=%b", n, stall, flush, new_pc, es, mem_excp);
      end
      checks++;
      if (mc_start !== launch || mc_cancel !== cancel) begin
        errors++;
        $display("FAIL rnd_mc[%0d]: start=%b cancel=%b want %b/%b", n, mc_start, mc_cancel, launch, cancel);
      end
      checks++;
      if (mc_timeout !== to || stall_cycles !== 4'(cnt)) begin
        errors++;
        $display("FAIL rnd_state[%0d]: to=%b cycles=%0d want %b/%0d", n, mc_timeout, stall_cycles, to, cnt);
      end
      if (rst) begin
        busy = 0; fin = 0; el = 0; to = 0; cnt = 0;
      end else begin
        if (es != 0 && cnt < 15) cnt++;
        if (launch) begin
          busy = 1; el = 0; fin = 0;
        end else if (busy) begin
          if (mem_excp) busy = 0;
          else if (mc_done) begin busy = 0; fin = 1; end
          else if (el == TO - 1) begin busy = 0; to = 1; end
          else el++;
        end else begin
          fin = 0;
        end
      end
      tick();
    end
    clear_inputs();
    rst = 0;
  endtask

  initial begin
    tick();
    test_reset();
    test_stall_id();
    test_stall_ex();
    test_mc_op();
    test_mc_excp();
    test_mc_timeout();
    test_rst_mid_run();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
